mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports RegWrite_in, MemToReg_in, MemRead_in and MemWrite_in, input, 1 each, EX/MEM control outputs.
REQ-004 SHALL have ports alu_result_in (input, 32, address or result), rs2_data_in (input, 32, store data), funct3_in (input, 3, access size/sign) and rd_in (input, 5).
REQ-005 SHALL have ports dmem_req, dmem_we (output, 1), dmem_addr, dmem_wdata (output, 32) and dmem_wstrb (output, 4), the data-memory request.
REQ-006 SHALL have ports dmem_ready (input, 1, access complete) and dmem_rdata (input, 32, aligned word read data).
REQ-007 SHALL have port stall_out, output, 1, which freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-008 SHALL have ports RegWrite_out, MemToReg_out (output, 1), alu_result_out, mem_rdata_out (output, 32) and rd_out (output, 5), registered MEM/WB values.
REQ-009 SHALL have ports misalign_out and bus_err_out, output, 1 each, single-cycle fault pulses.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT.
REQ-011 A memory op is MemRead_in or MemWrite_in; MemRead_in and MemWrite_in both high SHALL be treated as a store.
REQ-012 IDLE, no memory op: at the next edge, the MEM/WB outputs SHALL load their inputs (1-cycle latency); stall_out SHALL be 0; mem_rdata_out SHALL be 0.
REQ-013 IDLE, aligned memory op: stall_out SHALL be 1; at the next edge, register dmem_req=1, dmem_we, dmem_addr={alu_result_in[31:2],2'b00}, dmem_wdata and dmem_wstrb, and enter WAIT.
REQ-014 WAIT: the request outputs SHALL stay stable; stall_out SHALL equal !dmem_ready (combinational).
REQ-015 WAIT with dmem_ready=1: at the edge, drop dmem_req, write the MEM/WB outputs (load data extended per REQ-017), and return to IDLE; minimum memory-op latency is 2 cycles.
REQ-016 Every edge with stall_out=1 SHALL load a bubble: RegWrite_out=0, MemToReg_out=0.
REQ-017 Loads SHALL select bytes by address[1:0] from dmem_rdata, as follows.
- funct3 000 LB: sign-extend byte.
- funct3 001 LH: sign-extend halfword.
- funct3 010 LW: full word.
- funct3 100 LBU: zero-extend byte.
- funct3 101 LHU: zero-extend halfword.
- Other funct3: treat as LW.
REQ-018 Stores SHALL set dmem_wstrb and dmem_wdata, as follows.
- SB: wstrb=4'b0001<<addr[1:0]; byte replicated x4.
- SH: wstrb=4'b0011<<addr[1:0]; halfword replicated x2.
- SW: wstrb=4'b1111.
REQ-019 Stores SHALL complete with RegWrite_out forced to 0.
REQ-020 Misaligned access is halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 On a misaligned access in IDLE: issue no request, stall_out=0, pulse misalign_out for one cycle, and load MEM/WB with RegWrite_out=0.
REQ-022 dmem_ready while in IDLE SHALL be ignored.

Reset
REQ-023 On an edge with reset=1, the block SHALL enter IDLE and clear every registered output to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, all MEM/WB outputs, misalign_out and bus_err_out.
REQ-024 Reset during WAIT SHALL abandon the access; a dmem_ready on the following cycle SHALL be ignored.
REQ-025 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-026 With macro MEM_ACCESS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-027 With MEM_ACCESS_TIMEOUT_EN defined, when the counter reaches 255 without dmem_ready, the block SHALL drop dmem_req, pulse bus_err_out, load a bubble, and return to IDLE (stall_out=0 that cycle).
REQ-028 Without MEM_ACCESS_TIMEOUT_EN, WAIT SHALL last indefinitely and bus_err_out SHALL be tied to 0.

Verification
REQ-029 Bench SHALL cover: ADD, RegWrite_in=1, alu_result_in=0x0000_0010, rd_in=5 -> next cycle RegWrite_out=1, alu_result_out=0x10, rd_out=5, stall_out=0.
REQ-030 Bench SHALL cover: LB at addr 0x103, dmem_rdata=0x80FF_0000, ready on first WAIT cycle -> dmem_addr=0x100, stall high 1 cycle, mem_rdata_out=0xFFFF_FF80.
REQ-031 Bench SHALL cover: SH at addr 0x202, rs2=0x1234_ABCD, ready after 3 WAIT cycles -> wstrb=4'b1100, wdata=0xABCD_ABCD, 3 bubbles, RegWrite_out=0.
REQ-032 Bench SHALL cover: LW at addr 0x006 -> misalign_out pulses, dmem_req stays 0, RegWrite_out=0, no stall.
REQ-033 Bench SHALL cover: reset asserted in WAIT with late dmem_ready -> IDLE, all outputs 0, ready ignored.
REQ-034 Bench SHALL cover, with MEM_ACCESS_TIMEOUT_EN: dmem_ready held 0 -> bus_err_out pulses after 255 WAIT cycles, stall_out drops.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage with a two-state handshake to data memory.
// Loads/stores are issued from IDLE and held in WAIT until dmem_ready.
// Optional: define MEM_ACCESS_TIMEOUT_EN for a 255-cycle WAIT timeout with bus_err_out.
//
// state | meaning
// IDLE  | pass-through of EX/MEM; issue request for an aligned memory op
// WAIT  | request held on the bus, pipeline frozen until dmem_ready
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_rdata_out,
  output logic [4:0]  rd_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        mem_op, is_store, is_byte, is_half, misaligned;
  logic        issue, complete, timeout;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt, load_shift, load_data;
  // Operation captured at issue so completion does not depend on the frozen inputs.
  logic        op_store, op_regwrite, op_memtoreg;
  logic [2:0]  op_funct3;
  logic [4:0]  op_rd;
  logic [31:0] op_alu;

  assign mem_op     = MemRead_in | MemWrite_in;
  assign is_store   = MemWrite_in;
  assign is_byte    = (funct3_in[1:0] == 2'b00);
  assign is_half    = (funct3_in[1:0] == 2'b01);
  assign misaligned = mem_op & ((is_half & alu_result_in[0]) |
                      (!is_byte & !is_half & (alu_result_in[1:0] != 2'b00)));

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timeout = (state == WAIT) & !dmem_ready & (wait_cnt == 8'hFF);

  // WAIT-cycle counter and one-cycle bus error pulse on expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      bus_err_out <= 1'b0;
    end else begin
      bus_err_out <= timeout;
      if (issue)
        wait_cnt <= 8'd0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall and handshake decisions
  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall_out = 1'b1;
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane strobes and replicated write data
  always_comb begin
    wstrb_nxt = 4'b1111;
    wdata_nxt = rs2_data_in;
    if (is_byte) begin
      wstrb_nxt = 4'b0001 << alu_result_in[1:0];
      wdata_nxt = {4{rs2_data_in[7:0]}};
    end else if (is_half) begin
      wstrb_nxt = 4'b0011 << alu_result_in[1:0];
      wdata_nxt = {2{rs2_data_in[15:0]}};
    end
  end

  // Load lane select and extension
  always_comb begin
    load_shift = dmem_rdata >> {op_alu[1:0], 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'd0, load_shift[7:0]};
      3'b101:  load_data = {16'd0, load_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // Request registers, captured op and MEM/WB outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_wdata     <= 32'd0;
      dmem_wstrb     <= 4'd0;
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      alu_result_out <= 32'd0;
      mem_rdata_out  <= 32'd0;
      rd_out         <= 5'd0;
      misalign_out   <= 1'b0;
      op_store       <= 1'b0;
      op_regwrite    <= 1'b0;
      op_memtoreg    <= 1'b0;
      op_funct3      <= 3'd0;
      op_rd          <= 5'd0;
      op_alu         <= 32'd0;
    end else begin
      misalign_out <= 1'b0;
      if (state == IDLE) begin
        if (issue) begin
          dmem_req     <= 1'b1;
          dmem_we      <= is_store;
          dmem_addr    <= {alu_result_in[31:2], 2'b00};
          dmem_wdata   <= is_store ? wdata_nxt : 32'd0;
          dmem_wstrb   <= is_store ? wstrb_nxt : 4'd0;
          op_store     <= is_store;
          op_regwrite  <= RegWrite_in;
          op_memtoreg  <= MemToReg_in;
          op_funct3    <= funct3_in;
          op_rd        <= rd_in;
          op_alu       <= alu_result_in;
          RegWrite_out <= 1'b0;
          MemToReg_out <= 1'b0;
        end else begin
          RegWrite_out   <= RegWrite_in & !misaligned;
          MemToReg_out   <= MemToReg_in & !misaligned;
          alu_result_out <= alu_result_in;
          rd_out         <= rd_in;
          mem_rdata_out  <= 32'd0;
          misalign_out   <= misaligned;
        end
      end else if (complete) begin
        dmem_req       <= 1'b0;
        RegWrite_out   <= op_regwrite & !op_store;
        MemToReg_out   <= op_memtoreg & !op_store;
        alu_result_out <= op_alu;
        rd_out         <= op_rd;
        mem_rdata_out  <= op_store ? 32'd0 : load_data;
      end else begin
        if (timeout) dmem_req <= 1'b0;
        RegWrite_out <= 1'b0;
        MemToReg_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for mem_access_unit with hand-computed expectations.
// Build with +define+MEM_ACCESS_TIMEOUT_EN to exercise the WAIT timeout path.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
  logic [31:0] alu_result_in, rs2_data_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_out;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] alu_result_out, mem_rdata_out;
  logic [4:0]  rd_out;
  logic        misalign_out, bus_err_out;

  int n_total = 0;
  int n_bad   = 0;
  int n;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .funct3_in(funct3_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .alu_result_out(alu_result_out), .mem_rdata_out(mem_rdata_out),
    .rd_out(rd_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite_in = 0; MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    alu_result_in = 0; rs2_data_in = 0; funct3_in = 0; rd_in = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic set_op(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd);
    RegWrite_in = rw; MemToReg_in = m2r; MemRead_in = rd_en; MemWrite_in = wr_en;
    funct3_in = f3; alu_result_in = addr; rs2_data_in = rs2; rd_in = rd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   {31'd0, dmem_req}, 32'd0);
    chk({tag, "_we"},    {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"},  dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, 32'd0);
    chk({tag, "_rw"},    {31'd0, RegWrite_out}, 32'd0);
    chk({tag, "_m2r"},   {31'd0, MemToReg_out}, 32'd0);
    chk({tag, "_alu"},   alu_result_out, 32'd0);
    chk({tag, "_rdata"}, mem_rdata_out, 32'd0);
    chk({tag, "_rd"},    {27'd0, rd_out}, 32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_out}, 32'd0);
    chk({tag, "_berr"},  {31'd0, bus_err_out}, 32'd0);
  endtask

  // Load with ready on the first WAIT cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_op(1, 1, 1, 0, f3, addr, 32'd0, 5'd7);
    #1 chk({tag, "_stall0"}, {31'd0, stall_out}, 32'd1);
    step();
    chk({tag, "_req"},  {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_bub"},  {31'd0, RegWrite_out}, 32'd0);
    dmem_ready = 1; dmem_rdata = rdata;
    #1 chk({tag, "_stall1"}, {31'd0, stall_out}, 32'd0);
    step();
    dmem_ready = 0;
    chk({tag, "_reqdn"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_rw"},    {31'd0, RegWrite_out}, 32'd1);
    chk({tag, "_m2r"},   {31'd0, MemToReg_out}, 32'd1);
    chk({tag, "_data"},  mem_rdata_out, exp);
    chk({tag, "_rd"},    {27'd0, rd_out}, 32'd7);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step(); step();
    check_all_zero("rst");
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    reset = 0;

    // ALU pass-through
    set_op(1, 0, 0, 0, 3'b000, 32'h10, 32'd0, 5'd5);
    #1 chk("add_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("add_rw",    {31'd0, RegWrite_out}, 32'd1);
    chk("add_alu",   alu_result_out, 32'h10);
    chk("add_rd",    {27'd0, rd_out}, 32'd5);
    chk("add_rdata", mem_rdata_out, 32'd0);
    chk("add_req",   {31'd0, dmem_req}, 32'd0);
    idle_inputs();
    step();

    // Loads
    do_load("lb",  3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h101, 32'h1234_8056, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h002, 32'h8001_5555, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h002, 32'h8001_5555, 32'h0000_8001);
    do_load("lw",  3'b010, 32'h004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SH, ready on third WAIT cycle
    set_op(1, 0, 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9);
    n = 0;
    #1 if (stall_out) n++;
    step();
    chk("sh_req",   {31'd0, dmem_req}, 32'd1);
    chk("sh_we",    {31'd0, dmem_we}, 32'd1);
    chk("sh_addr",  dmem_addr, 32'h200);
    chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    for (int i = 0; i < 2; i++) begin
      #1 if (stall_out) n++;
      step();
      chk("sh_hold_strb", {28'd0, dmem_wstrb}, 32'hC);
      chk("sh_bub",       {31'd0, RegWrite_out}, 32'd0);
    end
    dmem_ready = 1;
    #1 chk("sh_stall_rdy", {31'd0, stall_out}, 32'd0);
    step();
    dmem_ready = 0;
    chk("sh_stalls", n, 32'd3);
    chk("sh_reqdn",  {31'd0, dmem_req}, 32'd0);
    chk("sh_rw",     {31'd0, RegWrite_out}, 32'd0);
    idle_inputs();
    step();

    // SB lane and replication
    set_op(0, 0, 0, 1, 3'b000, 32'h301, 32'h0000_00EF, 5'd0);
    step();
    chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
    dmem_ready = 1;
    step();
    idle_inputs();

    // Read and write together behave as a store
    set_op(0, 0, 1, 1, 3'b010, 32'h10, 32'h5A5A_0001, 5'd0);
    step();
    chk("rw_we",    {31'd0, dmem_we}, 32'd1);
    chk("rw_wstrb", {28'd0, dmem_wstrb}, 32'hF);
    dmem_ready = 1;
    step();
    idle_inputs();

    // Misaligned LW
    set_op(1, 1, 1, 0, 3'b010, 32'h006, 32'd0, 5'd4);
    #1 chk("mis_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("mis_pulse", {31'd0, misalign_out}, 32'd1);
    chk("mis_req",   {31'd0, dmem_req}, 32'd0);
    chk("mis_rw",    {31'd0, RegWrite_out}, 32'd0);
    idle_inputs();
    step();
    chk("mis_drop",  {31'd0, misalign_out}, 32'd0);

    // Reset during WAIT, late ready ignored
    set_op(1, 1, 1, 0, 3'b010, 32'h40, 32'd0, 5'd3);
    step();
    chk("rw_wait_req", {31'd0, dmem_req}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    idle_inputs();
    check_all_zero("rstw");
    dmem_ready = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("rstw_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("rstw_req2",   {31'd0, dmem_req}, 32'd0);
    chk("rstw_rw2",    {31'd0, RegWrite_out}, 32'd0);
    chk("rstw_rdata2", mem_rdata_out, 32'd0);
    idle_inputs();
    step();

    // Long wait: timeout if enabled, otherwise indefinite stall
    set_op(1, 1, 1, 0, 3'b010, 32'h80, 32'd0, 5'd2);
    step();
`ifdef MEM_ACCESS_TIMEOUT_EN
    n = 0;
    while (stall_out && n < 400) begin
      n++;
      step();
    end
    chk("to_cycles", n, 32'd255);
    chk("to_berr_pre", {31'd0, bus_err_out}, 32'd0);
    step();
    chk("to_berr", {31'd0, bus_err_out}, 32'd1);
    chk("to_req",  {31'd0, dmem_req}, 32'd0);
    chk("to_rw",   {31'd0, RegWrite_out}, 32'd0);
    idle_inputs();
    step();
    chk("to_berr_drop", {31'd0, bus_err_out}, 32'd0);
`else
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (stall_out) n++;
      step();
    end
    chk("nto_stall", n, 32'd300);
    chk("nto_berr",  {31'd0, bus_err_out}, 32'd0);
    chk("nto_req",   {31'd0, dmem_req}, 32'd1);
    dmem_ready = 1; dmem_rdata = 32'h0000_1111;
    step();
    chk("nto_data",  mem_rdata_out, 32'h0000_1111);
    chk("nto_reqdn", {31'd0, dmem_req}, 32'd0);
    idle_inputs();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
